// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
package cla_seq_adder_pkg;

  // Width of the time-shared carry-lookahead slice.
  localparam int SLICE_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Two's-complement overflow from the sign bits of both addends and the sum.
  // The b sign must be that of the operand actually added (inverted for subtract).
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return ~(a_msb ^ b_msb) & (a_msb ^ s_msb);
  endfunction

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// Combinational 4-bit carry-lookahead slice: propagate/generate,
// lookahead carries, and sum = p XOR carry-in of each bit.
module cla4_slice
  import cla_seq_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               c0,
  output logic [SLICE_W-1:0] s4,
  output logic               c4
);

  logic [SLICE_W-1:0] p_s;
  logic [SLICE_W-1:0] g_s;
  logic [SLICE_W-1:0] c_s;

  assign p_s = a4 ^ b4;
  assign g_s = a4 & b4;

  // Lookahead carries, each expanded directly from c0 so no bit ripples.
  always_comb begin
    c_s[0] = c0;
    c_s[1] = g_s[0] | (p_s[0] & c0);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c0);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & c0);
    c4     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c0);
  end

  assign s4 = p_s ^ c_s;

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that feeds one 4-bit CLA slice
// a nibble per clock, LSB nibble first, linked by a registered carry.
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SLICE_W-1:0] a_nib_s;
  logic [SLICE_W-1:0] b_nib_s;
  logic [SLICE_W-1:0] s_nib_s;
  logic               c_nib_s;
  logic               last_s;

  // Nibble mux: select the operand nibble addressed by idx.
  assign a_nib_s = a_q[idx_q*SLICE_W +: SLICE_W];
  assign b_nib_s = b_q[idx_q*SLICE_W +: SLICE_W];
  assign last_s  = (idx_q == IDX_W'(NSLICE - 1));

  cla4_slice u_slice (
    .a4 (a_nib_s),
    .b4 (b_nib_s),
    .c0 (carry_q),
    .s4 (s_nib_s),
    .c4 (c_nib_s)
  );

  // Next-state, operand loading, nibble demux and result capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = s_nib_s;
        carry_d = c_nib_s;
        if (last_s) begin
          // Top nibble: the slice output carries the final sign and carry.
          idx_d   = '0;
          cout_d  = c_nib_s;
          ovf_d   = calc_ovf(a_q[WIDTH-1], b_q[WIDTH-1], s_nib_s[SLICE_W-1]);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers; async reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed cases plus randomized
// operations compared against an integer-arithmetic reference model.
module tb_cla_seq_adder;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_total = 0;
  int n_pass  = 0;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;
  logic             exp_ovf;
  logic             hold_cout;
  logic             hold_ovf;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got !== expv) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: plain integer arithmetic on the accepted operands.
  task automatic model(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c);
    int r;
    logic [WIDTH:0] full;
    if (s) begin
      exp_sum  = x - y;
      exp_cout = (x >= y);
      r = int'($signed(x)) - int'($signed(y));
    end else begin
      full     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
      exp_sum  = full[WIDTH-1:0];
      exp_cout = full[WIDTH];
      r = int'($signed(x)) + int'($signed(y)) + int'(c);
    end
    exp_ovf = (r > 32767) || (r < -32768);
  endtask

  // Present a request at a negedge; it is accepted at the next posedge.
  task automatic issue(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c);
    sub   = s;
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    model(s, x, y, c);
  endtask

  // Follow one accepted operation to its done cycle; optionally wiggle inputs while busy.
  task automatic wait_done(input bit noise);
    int nb;
    nb = 0;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && nb < 20) begin
      check_eq("busy_run", 32'(busy), 32'd1);
      check_eq("cout_hold", 32'(cout), 32'(hold_cout));
      check_eq("ovf_hold", 32'(ovf), 32'(hold_ovf));
      if (noise) begin
        start = 1'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
      end
      nb++;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("latency", 32'(nb), 32'(NSLICE));
    check_eq("done", 32'(done), 32'd1);
    check_eq("busy_done", 32'(busy), 32'd0);
    check_eq("sum", 32'(sum), 32'(exp_sum));
    check_eq("cout", 32'(cout), 32'(exp_cout));
    check_eq("ovf", 32'(ovf), 32'(exp_ovf));
    hold_cout = exp_cout;
    hold_ovf  = exp_ovf;
  endtask

  // Cycle after done with no new start: pulse gone, result held.
  task automatic after_done();
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("sum_hold", 32'(sum), 32'(exp_sum));
    check_eq("cout_keep", 32'(cout), 32'(exp_cout));
    check_eq("ovf_keep", 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_sum"}, 32'(sum), 32'd0);
    check_eq({tag, "_cout"}, 32'(cout), 32'd0);
    check_eq({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  // Hard stop if the bench itself stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with start asserted: nothing is accepted.
    rst_n = 1'b0;
    start = 1'b1;
    sub   = 1'b0;
    a     = 16'h1234;
    b     = 16'h4321;
    cin   = 1'b0;
    hold_cout = 1'b0;
    hold_ovf  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_vals("rst");
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Basic add.
    issue(1'b0, 16'h1234, 16'h4321, 1'b0);
    wait_done(1'b0);
    after_done();
    check_eq("basic_sum", 32'(sum), 32'h5555);

    // Full ripple carry and positive overflow.
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait_done(1'b0);
    check_eq("ripple_sum", 32'(sum), 32'h0000);
    check_eq("ripple_cout", 32'(cout), 32'd1);
    after_done();
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    wait_done(1'b0);
    check_eq("povf_sum", 32'(sum), 32'h8000);
    check_eq("povf_ovf", 32'(ovf), 32'd1);
    after_done();

    // Subtract, carry-in ignored.
    issue(1'b1, 16'h0005, 16'h0007, 1'b1);
    wait_done(1'b0);
    check_eq("sub_sum", 32'(sum), 32'hFFFE);
    check_eq("sub_cout", 32'(cout), 32'd0);
    check_eq("sub_ovf", 32'(ovf), 32'd0);
    after_done();
    issue(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait_done(1'b0);
    check_eq("subovf_sum", 32'(sum), 32'h7FFF);
    check_eq("subovf_cout", 32'(cout), 32'd1);
    check_eq("subovf_ovf", 32'(ovf), 32'd1);
    after_done();

    // Start and operand changes during RUN are ignored.
    issue(1'b0, 16'h1234, 16'h4321, 1'b1);
    wait_done(1'b1);
    check_eq("ign_sum", 32'(sum), 32'h5556);
    after_done();

    // Back-to-back: start held in the DONE cycle.
    issue(1'b0, 16'hABCD, 16'h1111, 1'b0);
    wait_done(1'b0);
    issue(1'b1, 16'h0100, 16'h0200, 1'b0);
    wait_done(1'b0);
    check_eq("b2b_sum", 32'(sum), 32'hFF00);
    after_done();

    // Reset after two RUN cycles aborts the operation.
    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_vals("midrst_hold");
    end
    rst_n = 1'b1;
    hold_cout = 1'b0;
    hold_ovf  = 1'b0;
    @(negedge clk);
    check_eq("midrst_nodone", 32'(done), 32'd0);
    issue(1'b0, 16'h0F0F, 16'h00F1, 1'b0);
    wait_done(1'b0);
    check_eq("fresh_sum", 32'(sum), 32'h1000);
    after_done();

    // Randomized operations, some with noise or back-to-back.
    for (int k = 0; k < 40; k++) begin
      issue(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      wait_done(($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) != 0) begin
        after_done();
      end
    end
    after_done();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
